// File: rtl/dmem_store_buffer_pkg.sv
// dmem_store_buffer_pkg: shared bus width, store-entry type and log2 helper for the store buffer
package dmem_store_buffer_pkg;
  localparam int DATA_BUS_WIDTH = 32;
  typedef struct packed {
    logic [DATA_BUS_WIDTH-1:0] addr;
    logic [DATA_BUS_WIDTH-1:0] data;
  } sb_entry_t;
  function automatic int sb_log2(input int n);
    return $clog2(n);
  endfunction
endpackage

// File: rtl/dmem_store_buffer_sb_match.sv
// sb_match: youngest-first address search over buffer entries (i_addrs/i_valid/i_tail/i_addr in, o_hit/o_idx out)
module sb_match
  import dmem_store_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic [DEPTH*DATA_BUS_WIDTH-1:0] i_addrs,
  input  logic [DEPTH-1:0]                i_valid,
  input  logic [sb_log2(DEPTH)-1:0]       i_tail,
  input  logic [DATA_BUS_WIDTH-1:0]       i_addr,
  output logic                            o_hit,
  output logic [sb_log2(DEPTH)-1:0]       o_idx
);
  localparam int AW = sb_log2(DEPTH);
  logic [AW-1:0] w_j;
  always_comb begin
    o_hit = 1'b0;
    o_idx = '0;
    w_j = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      w_j = i_tail - AW'(k);
      if (i_valid[w_j] && i_addrs[int'(w_j)*DATA_BUS_WIDTH +: DATA_BUS_WIDTH] == i_addr) begin
        o_hit = 1'b1;
        o_idx = w_j;
      end
    end
  end
endmodule

// File: rtl/dmem_store_buffer.sv
// dmem_store_buffer: posted-store FIFO between core port (c_*) and single-port memory (m_*) with load forwarding, flush and empty
module dmem_store_buffer
  import dmem_store_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DATA_BUS_WIDTH-1:0] c_addr,
  input  logic                      c_wr,
  input  logic                      c_re,
  input  logic [DATA_BUS_WIDTH-1:0] c_wdata,
  output logic [DATA_BUS_WIDTH-1:0] c_rdata,
  output logic                      c_stall,
  output logic [DATA_BUS_WIDTH-1:0] m_addr,
  output logic                      m_wr,
  output logic                      m_re,
  output logic [DATA_BUS_WIDTH-1:0] m_wdata,
  input  logic [DATA_BUS_WIDTH-1:0] m_rdata,
  input  logic                      flush,
  output logic                      empty
);
  localparam int AW = sb_log2(DEPTH);
  sb_entry_t r_mem [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [AW-1:0] r_head, r_tail, w_idx;
  logic [AW:0] r_count;
  logic [DEPTH*DATA_BUS_WIDTH-1:0] w_addrs;
  logic w_full, w_load, w_flushing, w_drain, w_enq, w_hit;
  for (genvar g = 0; g < DEPTH; g++) begin : g_addr
    assign w_addrs[g*DATA_BUS_WIDTH +: DATA_BUS_WIDTH] = r_mem[g].addr;
  end
  sb_match #(.DEPTH(DEPTH)) u_match (
    .i_addrs(w_addrs),
    .i_valid(r_valid),
    .i_tail (r_tail),
    .i_addr (c_addr),
    .o_hit  (w_hit),
    .o_idx  (w_idx)
  );
  always_comb begin
    empty = r_count == '0;
    w_full = r_count == (AW+1)'(DEPTH);
    w_load = c_re && !c_wr;
    w_flushing = flush && !empty;
    w_drain = !empty && (!w_load || w_flushing);
    c_stall = w_flushing ? (c_wr || c_re) : (c_wr && w_full);
    w_enq = c_wr && !c_stall;
    m_wr = w_drain;
    m_re = w_load && !w_flushing;
    m_addr = w_drain ? r_mem[r_head].addr : c_addr;
    m_wdata = w_drain ? r_mem[r_head].data : '0;
    c_rdata = !m_re ? '0 : w_hit ? r_mem[w_idx].data : m_rdata;
  end
  always_ff @(posedge clk)
    if (w_enq) r_mem[r_tail] <= '{addr: c_addr, data: c_wdata};
  always_ff @(posedge clk) begin
    if (reset) begin
      r_head <= '0;
      r_tail <= '0;
      r_count <= '0;
      r_valid <= '0;
    end else begin
      r_head <= r_head + AW'(w_drain);
      r_tail <= r_tail + AW'(w_enq);
      r_count <= r_count + (AW+1)'(w_enq) - (AW+1)'(w_drain);
      r_valid <= (r_valid & ~(DEPTH'(w_drain) << r_head)) | (DEPTH'(w_enq) << r_tail);
    end
  end
endmodule

// File: tb/tb_dmem_store_buffer.sv
// tb_dmem_store_buffer: directed and randomized self-check of dmem_store_buffer against a queue plus shadow-memory model
module tb_dmem_store_buffer;
  import dmem_store_buffer_pkg::*;
  localparam int DEPTH = 4;
  localparam int NA = 8;
  logic clk = 1'b0, reset = 1'b1, c_wr = 1'b0, c_re = 1'b0, flush = 1'b0;
  logic [31:0] c_addr = '0, c_wdata = '0;
  logic [31:0] c_rdata, m_addr, m_wdata, m_rdata;
  logic c_stall, m_wr, m_re, empty;
  logic [31:0] tab [NA] = '{32'h0, 32'h100, 32'h200, 32'h300, 32'h8000_0100, 32'h0001_0200, 32'h4, 32'hFFFF_FFFC};
  logic [31:0] mem [NA+1];
  logic [31:0] shadow [NA+1];
  sb_entry_t q [$];
  int n_cmp = 0, n_bad = 0;
  bit started = 1'b0;
  always #5 clk = ~clk;
  dmem_store_buffer #(.DEPTH(DEPTH)) dut (
    .clk    (clk),
    .reset  (reset),
    .c_addr (c_addr),
    .c_wr   (c_wr),
    .c_re   (c_re),
    .c_wdata(c_wdata),
    .c_rdata(c_rdata),
    .c_stall(c_stall),
    .m_addr (m_addr),
    .m_wr   (m_wr),
    .m_re   (m_re),
    .m_wdata(m_wdata),
    .m_rdata(m_rdata),
    .flush  (flush),
    .empty  (empty)
  );
  function automatic int ix(input logic [31:0] a);
    for (int i = 0; i < NA; i++) if (tab[i] == a) return i;
    return NA;
  endfunction
  always_comb begin
    m_rdata = mem[NA];
    for (int i = 0; i < NA; i++) if (tab[i] == m_addr) m_rdata = mem[i];
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    int n;
    bit ld, fl, st, dr;
    #2;
    if (started) begin
      n = q.size();
      ld = c_re && !c_wr;
      fl = flush && n != 0;
      st = fl ? (c_re || c_wr) : (c_wr && n == DEPTH);
      dr = n != 0 && (!ld || fl);
      chk("empty", 32'(empty), 32'(n == 0));
      chk("c_stall", 32'(c_stall), 32'(st));
      chk("m_wr", 32'(m_wr), 32'(dr));
      chk("m_re", 32'(m_re), 32'(ld && !fl));
      chk("m_addr", m_addr, dr ? q[0].addr : c_addr);
      if (dr) chk("m_wdata", m_wdata, q[0].data);
      chk("c_rdata", c_rdata, (ld && !fl) ? shadow[ix(c_addr)] : 32'h0);
      if (dr) mem[ix(q[0].addr)] = q[0].data;
      if (reset) begin
        q.delete();
        for (int i = 0; i <= NA; i++) shadow[i] = mem[i];
      end else begin
        if (dr) void'(q.pop_front());
        if (c_wr && !st) begin
          q.push_back('{addr: c_addr, data: c_wdata});
          shadow[ix(c_addr)] = c_wdata;
        end
      end
    end
  end
  task automatic cyc(input bit rs, wr, re, fl, input logic [31:0] a, d);
    @(negedge clk);
    reset = rs;
    c_wr = wr;
    c_re = re;
    flush = fl;
    c_addr = a;
    c_wdata = d;
    #3;
  endtask
  initial begin
    int k;
    for (int i = 0; i <= NA; i++) begin
      mem[i] = $urandom;
      shadow[i] = mem[i];
    end
    repeat (2) @(posedge clk);
    started = 1'b1;
    cyc(1, 0, 0, 0, 32'h0, 32'h0);
    chk("rst_empty", 32'(empty), 32'h1);
    chk("rst_stall", 32'(c_stall), 32'h0);
    chk("rst_m_wr", 32'(m_wr), 32'h0);
    chk("rst_m_re", 32'(m_re), 32'h0);
    chk("rst_rdata", c_rdata, 32'h0);
    cyc(0, 1, 0, 0, 32'h100, 32'hAAAA);
    chk("st_empty", 32'(empty), 32'h1);
    chk("st_stall", 32'(c_stall), 32'h0);
    cyc(0, 0, 0, 0, 32'h0, 32'h0);
    chk("drain_wr", 32'(m_wr), 32'h1);
    chk("drain_addr", m_addr, 32'h100);
    chk("drain_data", m_wdata, 32'hAAAA);
    cyc(0, 0, 0, 0, 32'h0, 32'h0);
    chk("drained_empty", 32'(empty), 32'h1);
    chk("drained_wr", 32'(m_wr), 32'h0);
    mem[2] = 32'hDEAD; shadow[2] = 32'hDEAD;
    mem[3] = 32'hBEEF; shadow[3] = 32'hBEEF;
    mem[6] = 32'h1234; shadow[6] = 32'h1234;
    cyc(0, 1, 0, 0, 32'h200, 32'h1);
    cyc(0, 1, 0, 0, 32'h200, 32'h2);
    chk("st2_drain_data", m_wdata, 32'h1);
    cyc(0, 0, 1, 0, 32'h200, 32'h0);
    chk("fwd_rdata", c_rdata, 32'h2);
    chk("fwd_m_wr", 32'(m_wr), 32'h0);
    chk("fwd_m_re", 32'(m_re), 32'h1);
    cyc(0, 0, 1, 0, 32'h300, 32'h0);
    chk("miss_rdata", c_rdata, 32'hBEEF);
    chk("miss_m_re", 32'(m_re), 32'h1);
    chk("miss_m_addr", m_addr, 32'h300);
    cyc(0, 0, 0, 0, 32'h0, 32'h0);
    chk("idle_drain_data", m_wdata, 32'h2);
    cyc(0, 1, 1, 0, 32'h0, 32'h55);
    chk("both_m_re", 32'(m_re), 32'h0);
    chk("both_rdata", c_rdata, 32'h0);
    cyc(0, 0, 1, 1, 32'h0, 32'h0);
    chk("fl_stall", 32'(c_stall), 32'h1);
    chk("fl_m_re", 32'(m_re), 32'h0);
    chk("fl_rdata", c_rdata, 32'h0);
    chk("fl_m_wr", 32'(m_wr), 32'h1);
    chk("fl_m_wdata", m_wdata, 32'h55);
    cyc(0, 0, 1, 1, 32'h0, 32'h0);
    chk("fl_done_empty", 32'(empty), 32'h1);
    chk("fl_done_stall", 32'(c_stall), 32'h0);
    chk("fl_done_rdata", c_rdata, 32'h55);
    cyc(0, 1, 0, 0, 32'h4, 32'h77);
    cyc(0, 0, 1, 0, 32'h4, 32'h0);
    chk("pre_rst_fwd", c_rdata, 32'h77);
    chk("pre_rst_m_wr", 32'(m_wr), 32'h0);
    cyc(1, 0, 1, 0, 32'h4, 32'h0);
    cyc(0, 0, 0, 0, 32'h0, 32'h0);
    chk("post_rst_empty", 32'(empty), 32'h1);
    chk("post_rst_m_wr", 32'(m_wr), 32'h0);
    cyc(0, 0, 1, 0, 32'h4, 32'h0);
    chk("post_rst_rdata", c_rdata, 32'h1234);
    cyc(0, 1, 0, 0, 32'h8000_0100, 32'h99);
    cyc(0, 0, 1, 0, 32'h100, 32'h0);
    chk("hi_addr_no_alias", c_rdata, 32'hAAAA);
    cyc(0, 0, 0, 0, 32'h0, 32'h0);
    for (int t = 0; t < 3000; t++) begin
      k = $urandom_range(0, 19);
      cyc($urandom_range(0, 99) < 2, k < 7 || k == 19, (k >= 7 && k < 14) || k == 19,
          $urandom_range(0, 9) == 0, tab[$urandom_range(0, NA-1)], $urandom);
    end
    cyc(0, 0, 0, 0, 32'h0, 32'h0);
    cyc(0, 0, 0, 0, 32'h0, 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
